// File: rtl/hilo_muldiv.sv
// HI/LO special registers with an iterative radix-2 multiply/divide engine.
// MULT/DIV take DATA_W RUN cycles plus one FIX cycle; MTHI/MTLO write in one edge.
module hilo_muldiv #(
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk_50M,
  input  logic              cpu_rst_n,
  input  logic              op_valid_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] rs_i,
  input  logic [DATA_W-1:0] rt_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam int W2    = 2 * DATA_W;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] hi_q, lo_q, b_q, rs_q;
  logic [W2-1:0]     acc_q, acc_d, prod_fix;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, done_q;
  logic              div_q, neg_q, rneg_q, dz_q;

  logic              accept, is_mul, is_div, sgn;
  logic [DATA_W-1:0] a_mag, b_mag, quo_fix, rem_fix;
  logic [DATA_W:0]   sum, shl, diff;

  always_comb begin
    accept = op_valid_i && (state_q == IDLE) && !flush_i;
    is_mul = (op_i[2:1] == 2'b00);
    is_div = (op_i[2:1] == 2'b01);
    sgn    = !op_i[0];
    a_mag  = (sgn && rs_i[DATA_W-1]) ? -rs_i : rs_i;
    b_mag  = (sgn && rt_i[DATA_W-1]) ? -rt_i : rt_i;
    sum    = {1'b0, acc_q[W2-1:DATA_W]} + {1'b0, b_q};
    shl    = {acc_q[W2-1:DATA_W], acc_q[DATA_W-1]};
    diff   = shl - {1'b0, b_q};
    // acc holds {partial product, multiplier} or {remainder, quotient}
    if (div_q) begin
      acc_d = diff[DATA_W]
            ? {shl[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0}
            : {diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
    end else begin
      acc_d = acc_q[0]
            ? {sum, acc_q[DATA_W-1:1]}
            : {1'b0, acc_q[W2-1:1]};
    end
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    rem_fix  = rneg_q ? -acc_q[W2-1:DATA_W] : acc_q[W2-1:DATA_W];
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      rs_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (op_i == 3'b100) begin
              hi_q <= rs_i;
            end else if (op_i == 3'b101) begin
              lo_q <= rs_i;
            end else if (is_mul || is_div) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              cnt_q   <= CNT_W'(DATA_W - 1);
              div_q   <= is_div;
              neg_q   <= sgn && (rs_i[DATA_W-1] ^ rt_i[DATA_W-1]);
              rneg_q  <= sgn && rs_i[DATA_W-1];
              dz_q    <= is_div && (rt_i == '0);
              rs_q    <= rs_i;
              acc_q   <= {{DATA_W{1'b0}}, a_mag};
              b_q     <= b_mag;
            end
          end
        end
        RUN: begin
          if (flush_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) state_q <= FIX;
          end
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          if (!flush_i) begin
            done_q <= 1'b1;
            if (dz_q) begin
              hi_q <= rs_q;
              lo_q <= '1;
            end else if (div_q) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: directed and random MULT/DIV,
// MTHI/MTLO, flush and reset cases against an arithmetic reference.
module tb_hilo_muldiv;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid_i;
  logic [2:0]  op_i;
  logic [31:0] rs_i, rt_i;
  logic        flush_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] model_hi, model_lo;

  hilo_muldiv #(.DATA_W(32)) dut (
    .cpu_clk_50M(clk),
    .cpu_rst_n  (rst_n),
    .op_valid_i (op_valid_i),
    .op_i       (op_i),
    .rs_i       (rs_i),
    .rt_i       (rt_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference: {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] ref_res(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint sp;
    logic [63:0] ua, ub;
    int sa, sb, q, r;
    ref_res = '0;
    sa = a;
    sb = b;
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      3'd0: begin
        sp = longint'(sa) * longint'(sb);
        ref_res = sp;
      end
      3'd1: ref_res = ua * ub;
      3'd2: begin
        if (b == 0) ref_res = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          ref_res = {32'h0, 32'h80000000};
        else begin
          q = sa / sb;
          r = sa % sb;
          ref_res = {r, q};
        end
      end
      3'd3: begin
        if (b == 0) ref_res = {a, 32'hFFFFFFFF};
        else ref_res = {a % b, a / b};
      end
      default: ;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && done_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done hi=%h lo=%h", hi_o, lo_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_hilo", {hi_o, lo_o}, mon_e);
      end
    end
  end

  // Present an op for one edge, then scramble operands
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    op_valid_i = 1'b1;
    op_i = op;
    rs_i = a;
    rt_i = b;
    @(negedge clk);
    op_valid_i = 1'b0;
    rs_i = $urandom;
    rt_i = $urandom;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit mt_busy);
    logic [63:0] e;
    int nbusy;
    e = ref_res(op, a, b);
    exp_q.push_back(e);
    issue(op, a, b);
    nbusy = 0;
    while (busy_o && nbusy < 100) begin
      nbusy++;
      if (mt_busy && nbusy == 5) begin
        op_valid_i = 1'b1;
        op_i = 3'b100;
        rs_i = 32'hDEADBEEF;
      end else begin
        op_valid_i = 1'b0;
      end
      @(negedge clk);
    end
    op_valid_i = 1'b0;
    chk("busy_cycles", 64'(nbusy), 64'd33);
    chk("done_pulse", {63'b0, done_o}, 64'd1);
    @(negedge clk);
    chk("done_single", {63'b0, done_o}, 64'd0);
    model_hi = e[63:32];
    model_lo = e[31:0];
  endtask

  task automatic mt(input logic [2:0] op, input logic [31:0] d);
    @(negedge clk);
    op_valid_i = 1'b1;
    op_i = op;
    rs_i = d;
    @(negedge clk);
    op_valid_i = 1'b0;
    if (op == 3'b100) model_hi = d;
    else model_lo = d;
    chk("mt_hilo", {hi_o, lo_o}, {model_hi, model_lo});
    chk("mt_busy", {63'b0, busy_o}, 64'd0);
  endtask

  task automatic flush_op(input int at);
    mt(3'b100, 32'hAAAA0000);
    mt(3'b101, 32'h0000BBBB);
    issue(3'b001, 32'd3, 32'd5);
    for (int k = 1; k < at; k++) @(negedge clk);
    chk("busy_before_flush", {63'b0, busy_o}, 64'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_busy", {63'b0, busy_o}, 64'd0);
    chk("flush_hilo", {hi_o, lo_o}, {32'hAAAA0000, 32'h0000BBBB});
    chk("flush_done", {63'b0, done_o}, 64'd0);
    repeat (3) @(negedge clk);
    chk("flush_hilo_later", {hi_o, lo_o}, {32'hAAAA0000, 32'h0000BBBB});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: pick = 32'h0;
      1: pick = 32'hFFFFFFFF;
      2: pick = 32'h80000000;
      3: pick = $urandom_range(0, 15);
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    op_valid_i = 1'b0;
    op_i = 3'b0;
    rs_i = '0;
    rt_i = '0;
    flush_i = 1'b0;
    model_hi = '0;
    model_lo = '0;
    repeat (2) @(negedge clk);
    chk("rst_hilo", {hi_o, lo_o}, 64'd0);
    chk("rst_busy_done", {62'b0, busy_o, done_o}, 64'd0);
    rst_n = 1'b1;

    run_op(3'b000, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    run_op(3'b001, 32'hFFFFFFFF, 32'h00000002, 1'b0);
    run_op(3'b010, 32'hFFFFFFF9, 32'h00000002, 1'b0);
    run_op(3'b011, 32'd7, 32'd2, 1'b0);
    run_op(3'b010, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_op(3'b011, 32'd7, 32'd0, 1'b0);
    run_op(3'b010, 32'hFFFFFFF9, 32'd0, 1'b0);

    // MTHI then MTLO on consecutive cycles
    @(negedge clk);
    op_valid_i = 1'b1;
    op_i = 3'b100;
    rs_i = 32'h12345678;
    @(negedge clk);
    chk("b2b_hi", {hi_o, lo_o}, {32'h12345678, model_lo});
    chk("b2b_busy1", {63'b0, busy_o}, 64'd0);
    op_i = 3'b101;
    rs_i = 32'h9ABCDEF0;
    @(negedge clk);
    op_valid_i = 1'b0;
    chk("b2b_lo", {hi_o, lo_o}, {32'h12345678, 32'h9ABCDEF0});
    chk("b2b_busy2", {63'b0, busy_o}, 64'd0);
    model_hi = 32'h12345678;
    model_lo = 32'h9ABCDEF0;

    // MTHI blocked by flush in IDLE, reserved op ignored
    @(negedge clk);
    op_valid_i = 1'b1;
    op_i = 3'b100;
    rs_i = 32'h55555555;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    op_i = 3'b110;
    @(negedge clk);
    op_valid_i = 1'b0;
    chk("idle_flush_rsvd", {hi_o, lo_o}, {model_hi, model_lo});
    chk("rsvd_busy", {63'b0, busy_o}, 64'd0);

    run_op(3'b001, 32'h00010000, 32'h00030000, 1'b1);

    flush_op(10);
    flush_op(33);
    model_hi = 32'hAAAA0000;
    model_lo = 32'h0000BBBB;

    // Reset in the middle of a divide
    issue(3'b010, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_hilo", {hi_o, lo_o}, 64'd0);
    chk("midrst_busy", {62'b0, busy_o, done_o}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    repeat (40) @(negedge clk);
    chk("midrst_quiet", {hi_o, lo_o}, 64'd0);

    for (int i = 0; i < 24; i++)
      run_op(3'($urandom_range(0, 3)), pick(), pick(), 1'b0);

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- HI/LO special-register unit with an integrated iterative multiply/divide engine. It replaces the plain HI/LO register pair.
- Sits in the EX stage. The pipeline issues one op per accept. The unit asserts busy_o while iterating, and the pipeline stalls any HI/LO-dependent instruction on busy_o.
- HI/LO are also directly writable (MTHI/MTLO) and always readable asynchronously from registers.

Parameters:
DATA_W, 32, operand/HI/LO width; must be even and >= 4
CNT_W, $clog2(DATA_W), iteration counter width (derived, not overridden)

Ports:
cpu_clk_50M  input  1  system clock, all state on rising edge
cpu_rst_n  input  1  synchronous active-low reset
op_valid_i  input  1  op request this cycle
op_i  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved (ignored)
rs_i  input  DATA_W  operand A / dividend / MTHI-MTLO data
rt_i  input  DATA_W  operand B / divisor
flush_i  input  1  abort in-flight op (exception/branch flush)
busy_o  output  1  engine iterating; new ops not accepted
done_o  output  1  one-cycle pulse: HI/LO just updated by MULT/DIV
hi_o  output  DATA_W  HI register
lo_o  output  DATA_W  LO register

Behaviour:
- Reset (cpu_rst_n=0 at edge): hi_o=0, lo_o=0, state=IDLE, busy_o=0, done_o=0, counter=0. Takes effect regardless of state, so a mid-operation reset discards the op.
- States: IDLE, RUN, FIX.
- Accept rule: op_valid_i && state==IDLE && !flush_i. Ops presented while busy_o=1 or while flush_i=1 are dropped; the caller must hold/stall. Reserved op_i codes are ignored.
- MTHI/MTLO:
  - Accepted in IDLE; writes rs_i to HI (or LO) at that edge.
  - The other register is unchanged. No busy, no done_o.
  - Back-to-back MTHI then MTLO on consecutive cycles is legal.
- MULT/MULTU/DIV/DIVU accept:
  - rs_i/rt_i are latched at the accept edge (later input changes are irrelevant).
  - Signed ops latch magnitudes plus result-sign flags.
  - Go to RUN with counter=DATA_W-1.
- RUN:
  - One radix-2 step per cycle: shift-add for multiply, restoring shift-subtract for divide, on unsigned magnitudes.
  - Counter decrements. At counter==0 the next state is FIX.
- FIX (1 cycle):
  - Apply sign correction.
  - Multiply: 2*DATA_W product negated if signs differ; HI=upper half, LO=lower half.
  - Divide: quotient negated if signs differ; remainder takes the dividend's sign; LO=quotient, HI=remainder.
  - Write HI and LO at the FIX->IDLE edge; done_o=1 for the following cycle only.
- busy_o = (state==RUN || state==FIX), registered.
- Latency: accept at edge T; busy_o high for DATA_W+1 cycles; new HI/LO and done_o visible after edge T+DATA_W+1. The next op is accepted at the earliest at edge T+DATA_W+2.
- Divide by zero (rt==0, signed or unsigned): HI=rs (original, unsigned/signed as given), LO=all ones. Takes full latency and pulses done_o.
- Signed overflow: MIN_INT/-1 gives LO=MIN_INT, HI=0 (natural wrap of magnitude algorithm).
- flush_i:
  - In RUN/FIX, the unit returns to IDLE at the next edge.
  - HI/LO are not written and no done_o is produced.
  - flush_i has priority over the FIX write on the same edge.
  - In IDLE it only blocks acceptance.
- Reads are always combinational from the registers. During RUN, hi_o/lo_o hold pre-op values.

Test Plan:
- MULT rs=0xFFFFFFFF, rt=0x00000002 -> busy_o 33 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE, done_o single pulse. MULTU same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU rs=7, rt=2 -> LO=3, HI=1. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU rs=7, rt=0 -> HI=0x00000007, LO=0xFFFFFFFF after full latency, done_o pulses.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on next cycle -> HI/LO updated one edge each, busy_o never asserted. MTHI issued while busy -> ignored, HI unchanged after op completes with MULT result.
- Preload HI=0xAAAA0000, LO=0x0000BBBB; start MULTU 3*5; assert flush_i at cycle 10 of RUN -> IDLE next edge, HI/LO unchanged, no done_o. Repeat with flush_i in FIX cycle -> same.
- Start DIV, drive cpu_rst_n=0 mid-RUN and change rs_i/rt_i after accept in a separate run -> reset gives HI=LO=0, busy_o=0; operand change gives result from latched values.
